// File: rtl/alu_wide_pkg.sv
// Shared types and constants for the 64-bit-on-32-bit ALU sequencer.
package alu_wide_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_RSB = 3'b101,
        OP_ADC = 3'b110,
        OP_SBC = 3'b111
    } wide_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } seq_state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0100;
    localparam logic [3:0] ALU_RSB = 4'b0101;
    localparam logic [3:0] ALU_ADC = 4'b1000;
    localparam logic [3:0] ALU_SBC = 4'b1001;
    localparam logic [3:0] ALU_RSC = 4'b1101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_wide_seq_if.sv
// Request/response handshake bundle between the wide-op issuer and the sequencer.
interface alu_wide_seq_if #(parameter int XLEN = 32);
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [2*XLEN-1:0]   req_a;
    logic [2*XLEN-1:0]   req_b;
    logic                req_cin;
    logic                resp_valid;
    logic                resp_ready;
    logic [2*XLEN-1:0]   resp_result;
    logic [3:0]          resp_flags;
    logic                busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_flags, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, resp_ready,
        output req_ready, resp_valid, resp_result, resp_flags, busy
    );
endinterface

// File: rtl/alu.sv
// 32-bit ALU: ARM-style add/sub family with carry chaining plus AND/ORR/EOR; flags {N,Z,C,V}.
module alu
    import alu_wide_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_srca,
    input  logic [XLEN-1:0] i_srcb,
    input  logic [3:0]      i_ctrl,
    input  logic            i_carry,
    output logic [XLEN-1:0] o_result,
    output logic [3:0]      o_flags
);
    logic [XLEN-1:0] w_x;
    logic [XLEN-1:0] w_y;
    logic            w_cin;
    logic            w_is_logic;
    logic [XLEN:0]   w_sum;

    // Every arithmetic op is x + y + cin; subtraction inverts one operand.
    always_comb begin
        w_x        = i_srca;
        w_y        = i_srcb;
        w_cin      = 1'b0;
        w_is_logic = 1'b0;
        case (i_ctrl)
            ALU_SUB: begin w_y = ~i_srcb; w_cin = 1'b1; end
            ALU_RSB: begin w_x = i_srcb; w_y = ~i_srca; w_cin = 1'b1; end
            ALU_ADC: w_cin = i_carry;
            ALU_SBC: begin w_y = ~i_srcb; w_cin = i_carry; end
            ALU_RSC: begin w_x = i_srcb; w_y = ~i_srca; w_cin = i_carry; end
            ALU_AND, ALU_ORR, ALU_EOR: w_is_logic = 1'b1;
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{XLEN{1'b0}}, w_cin};

    always_comb begin
        case (i_ctrl)
            ALU_AND: o_result = i_srca & i_srcb;
            ALU_ORR: o_result = i_srca | i_srcb;
            ALU_EOR: o_result = i_srca ^ i_srcb;
            default: o_result = w_sum[XLEN-1:0];
        endcase
    end

    assign o_flags = {o_result[XLEN-1],
                      o_result == '0,
                      w_is_logic ? 1'b0 : w_sum[XLEN],
                      w_is_logic ? 1'b0 : ((w_x[XLEN-1] == w_y[XLEN-1]) && (w_sum[XLEN-1] != w_x[XLEN-1]))};
endmodule

// File: rtl/alu_wide_ctrl_map.sv
// Maps a wide op and word phase onto the 32-bit ALU control code and carry input.
module alu_wide_ctrl_map
    import alu_wide_pkg::*;
(
    input  wide_op_t    i_op,
    input  logic        i_phase_hi,
    input  logic        i_lo_c,
    input  logic        i_cin,
    output logic [3:0]  o_ctrl,
    output logic        o_carry,
    output logic        o_is_logic
);
    always_comb begin
        o_ctrl     = ALU_ADD;
        o_carry    = 1'b0;
        o_is_logic = 1'b0;
        // High word of arithmetic ops always switches to the carry-consuming variant.
        case (i_op)
            OP_ADD: begin o_ctrl = i_phase_hi ? ALU_ADC : ALU_ADD; o_carry = i_phase_hi & i_lo_c; end
            OP_SUB: begin o_ctrl = i_phase_hi ? ALU_SBC : ALU_SUB; o_carry = i_phase_hi & i_lo_c; end
            OP_RSB: begin o_ctrl = i_phase_hi ? ALU_RSC : ALU_RSB; o_carry = i_phase_hi & i_lo_c; end
            OP_ADC: begin o_ctrl = ALU_ADC; o_carry = i_phase_hi ? i_lo_c : i_cin; end
            OP_SBC: begin o_ctrl = ALU_SBC; o_carry = i_phase_hi ? i_lo_c : i_cin; end
            OP_AND: begin o_ctrl = ALU_AND; o_is_logic = 1'b1; end
            OP_ORR: begin o_ctrl = ALU_ORR; o_is_logic = 1'b1; end
            OP_EOR: begin o_ctrl = ALU_EOR; o_is_logic = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_wide_seq.sv
// Runs one 64-bit op as two passes through an external 32-bit ALU, low word first.
module alu_wide_seq
    import alu_wide_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_wide_seq_if.slave   bus,
    output logic [XLEN-1:0] alu_srca,
    output logic [XLEN-1:0] alu_srcb,
    output logic [3:0]      alu_ctrl,
    output logic            alu_carry,
    input  logic [XLEN-1:0] alu_result,
    input  logic [3:0]      alu_flags
);
    seq_state_t        r_state;
    wide_op_t          r_op;
    logic [2*XLEN-1:0] r_a;
    logic [2*XLEN-1:0] r_b;
    logic              r_cin;
    logic [XLEN-1:0]   r_lo;
    logic              r_lo_zero;
    logic              r_lo_c;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_busy;
    logic [2*XLEN-1:0] r_resp_result;
    logic [3:0]        r_resp_flags;

    logic              w_phase_hi;
    logic              w_active;
    logic [3:0]        w_ctrl;
    logic              w_carry;
    logic              w_is_logic;

    assign w_phase_hi = (r_state == ST_HI);
    assign w_active   = (r_state == ST_LO) || (r_state == ST_HI);

    alu_wide_ctrl_map u_ctrl_map (
        .i_op       (r_op),
        .i_phase_hi (w_phase_hi),
        .i_lo_c     (r_lo_c),
        .i_cin      (r_cin),
        .o_ctrl     (w_ctrl),
        .o_carry    (w_carry),
        .o_is_logic (w_is_logic)
    );

    // ALU is driven only while a word is in flight; otherwise parked at zero.
    assign alu_ctrl  = w_active ? w_ctrl : ALU_ADD;
    assign alu_carry = w_active ? w_carry : 1'b0;
    assign alu_srca  = (r_state == ST_LO) ? r_a[XLEN-1:0] : (w_phase_hi ? r_a[2*XLEN-1:XLEN] : '0);
    assign alu_srcb  = (r_state == ST_LO) ? r_b[XLEN-1:0] : (w_phase_hi ? r_b[2*XLEN-1:XLEN] : '0);

    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_flags  = r_resp_flags;
    assign bus.busy        = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_ADD;
            r_a           <= '0;
            r_b           <= '0;
            r_cin         <= 1'b0;
            r_lo          <= '0;
            r_lo_zero     <= 1'b0;
            r_lo_c        <= 1'b0;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_resp_result <= '0;
            r_resp_flags  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op        <= wide_op_t'(bus.req_op);
                        r_a         <= bus.req_a;
                        r_b         <= bus.req_b;
                        r_cin       <= bus.req_cin;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LO;
                    end
                end
                ST_LO: begin
                    r_lo      <= alu_result;
                    r_lo_zero <= alu_flags[FLAG_Z];
                    r_lo_c    <= alu_flags[FLAG_C];
                    r_state   <= ST_HI;
                end
                ST_HI: begin
                    // Logic ops have no meaningful carry/overflow, so C and V are cleared.
                    r_resp_result <= {alu_result, r_lo};
                    r_resp_flags  <= {alu_flags[FLAG_N],
                                      r_lo_zero & alu_flags[FLAG_Z],
                                      w_is_logic ? 2'b00 : alu_flags[FLAG_C:FLAG_V]};
                    r_resp_valid  <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench: directed vectors, multi-cycle corner sequences and random ops vs a 64-bit model.
module tb_alu_wide_seq;
    import alu_wide_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_ctrl, alu_flags;
    logic        alu_carry;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_wide_seq_if #(.XLEN(XLEN)) bus_if ();

    alu #(.XLEN(XLEN)) u_alu (
        .i_srca   (alu_srca),
        .i_srcb   (alu_srcb),
        .i_ctrl   (alu_ctrl),
        .i_carry  (alu_carry),
        .o_result (alu_result),
        .o_flags  (alu_flags)
    );

    alu_wide_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_carry  (alu_carry),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Whole 64-bit operation in one step: operands as 2's-complement integers, ARM carry.
    function automatic void ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, output logic [63:0] r, output logic [3:0] f);
        logic [64:0] s;
        logic [63:0] x, y;
        logic        c;
        logic        arith;
        x = a; y = b; c = 1'b0; arith = 1'b1; r = '0;
        case (op)
            OP_ADD: begin x = a; y = b;  c = 1'b0; end
            OP_SUB: begin x = a; y = ~b; c = 1'b1; end
            OP_RSB: begin x = b; y = ~a; c = 1'b1; end
            OP_ADC: begin x = a; y = b;  c = cin;  end
            OP_SBC: begin x = a; y = ~b; c = cin;  end
            OP_AND: begin arith = 1'b0; r = a & b; end
            OP_ORR: begin arith = 1'b0; r = a | b; end
            default: begin arith = 1'b0; r = a ^ b; end
        endcase
        if (arith) begin
            s = {1'b0, x} + {1'b0, y} + {64'd0, c};
            r = s[63:0];
            f = {r[63], r == 64'd0, s[64], (x[63] == y[63]) && (r[63] != x[63])};
        end else begin
            f = {r[63], r == 64'd0, 2'b00};
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after an edge with the response captured.
    task automatic do_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input bit release_resp,
                          output logic [63:0] res, output logic [3:0] flg, output int lat);
        int w;
        w = 0;
        res = '0; flg = '0; lat = 0;
        while (!bus_if.req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!bus_if.req_ready) begin
            check("req_ready_wait", {63'd0, bus_if.req_ready}, 64'd1);
            return;
        end
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_a     = a;
        bus_if.req_b     = b;
        bus_if.req_cin   = cin;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        lat = 1;
        while (!bus_if.resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus_if.resp_valid) begin
            check("resp_valid_wait", {63'd0, bus_if.resp_valid}, 64'd1);
            return;
        end
        res = bus_if.resp_result;
        flg = bus_if.resp_flags;
        if (release_resp) begin
            bus_if.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus_if.resp_ready = 1'b0;
        end
    endtask

    vec_t        vecs [6];
    logic [63:0] res, exp_r, ra, rb;
    logic [3:0]  flg, exp_f;
    logic [2:0]  rop;
    logic        rcin;
    int          lat;
    bit          saw_valid;

    initial begin
        vecs[0] = '{"add_carry", OP_ADD, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 4'b0000};
        vecs[1] = '{"sub_zero",  OP_SUB, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, 64'h0, 4'b0110};
        vecs[2] = '{"add_ovf",   OP_ADD, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 4'b1001};
        vecs[3] = '{"rsb",       OP_RSB, 64'h3, 64'h1_00000000, 1'b0, 64'h00000000_FFFFFFFD, 4'b0010};
        vecs[4] = '{"sbc_cin0",  OP_SBC, 64'h5, 64'h2, 1'b0, 64'h2, 4'b0010};
        vecs[5] = '{"eor_zero",  OP_EOR, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 1'b0, 64'h0, 4'b0100};

        reset = 1'b1;
        bus_if.req_valid = 1'b0; bus_if.req_op = '0; bus_if.req_a = '0; bus_if.req_b = '0;
        bus_if.req_cin = 1'b0; bus_if.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid",  {63'd0, bus_if.resp_valid}, 64'd0);
        check("rst_resp_result", bus_if.resp_result, 64'd0);
        check("rst_resp_flags",  {60'd0, bus_if.resp_flags}, 64'd0);
        check("rst_busy",        {63'd0, bus_if.busy}, 64'd0);
        check("rst_req_ready",   {63'd0, bus_if.req_ready}, 64'd1);
        check("rst_alu_ctrl",    {60'd0, alu_ctrl}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, res, flg, lat);
            $display("[TB] %s op=%0d a=%h b=%h -> result=%h flags=%b latency=%0d",
                     vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, res, flg, lat);
            check({vecs[i].name, "_result"}, res, vecs[i].exp_r);
            check({vecs[i].name, "_flags"}, {60'd0, flg}, {60'd0, vecs[i].exp_f});
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd3);
        end

        // Backpressure: response held while resp_ready is low; a waiting request must not slip in.
        do_req(OP_ADD, 64'd5, 64'd7, 1'b0, 1'b0, res, flg, lat);
        $display("[TB] backpressure ADD 5+7 -> result=%h flags=%b latency=%0d", res, flg, lat);
        bus_if.req_valid = 1'b1; bus_if.req_op = OP_ADD; bus_if.req_a = 64'd3; bus_if.req_b = 64'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_result",    bus_if.resp_result, 64'd12);
            check("bp_flags",     {60'd0, bus_if.resp_flags}, 64'd0);
            check("bp_valid",     {63'd0, bus_if.resp_valid}, 64'd1);
            check("bp_req_ready", {63'd0, bus_if.req_ready}, 64'd0);
        end
        bus_if.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.resp_ready = 1'b0;
        check("bp_rel_ready", {63'd0, bus_if.req_ready}, 64'd1);
        check("bp_rel_valid", {63'd0, bus_if.resp_valid}, 64'd0);
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        check("bp_next_busy", {63'd0, bus_if.busy}, 64'd1);
        lat = 1;
        while (!bus_if.resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        $display("[TB] backpressure follow-up ADD 3+4 -> result=%h latency=%0d", bus_if.resp_result, lat);
        check("bp_next_result", bus_if.resp_result, 64'd7);
        check("bp_next_latency", 64'(lat), 64'd3);
        bus_if.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.resp_ready = 1'b0;

        // Reset arriving while the high word is on the ALU aborts the request.
        bus_if.req_valid = 1'b1; bus_if.req_op = OP_ADD;
        bus_if.req_a = 64'h0000_0001_FFFF_FFFF; bus_if.req_b = 64'h1;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        @(posedge clk); #1;
        check("hi_alu_ctrl", {60'd0, alu_ctrl}, {60'd0, ALU_ADC});
        reset = 1'b1;
        #1;
        check("abort_busy",      {63'd0, bus_if.busy}, 64'd0);
        check("abort_req_ready", {63'd0, bus_if.req_ready}, 64'd1);
        check("abort_valid",     {63'd0, bus_if.resp_valid}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus_if.resp_valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", {63'd0, saw_valid}, 64'd0);
        do_req(OP_ADD, 64'd1, 64'd1, 1'b0, 1'b1, res, flg, lat);
        $display("[TB] after abort ADD 1+1 -> result=%h flags=%b latency=%0d", res, flg, lat);
        check("after_abort_result", res, 64'd2);

        for (int i = 0; i < 150; i++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rop  = 3'($urandom_range(0, 7));
            rcin = 1'($urandom);
            case ($urandom_range(0, 3))
                0: ra[31:0] = 32'hFFFF_FFFF;
                1: rb = ra;
                2: rb[31:0] = ra[31:0];
                default: ;
            endcase
            ref_model(rop, ra, rb, rcin, exp_r, exp_f);
            do_req(rop, ra, rb, rcin, 1'b1, res, flg, lat);
            $display("[TB] rand%0d op=%0d a=%h b=%h cin=%0d -> result=%h flags=%b",
                     i, rop, ra, rb, rcin, res, flg);
            check("rand_result", res, exp_r);
            check("rand_flags", {60'd0, flg}, {60'd0, exp_f});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
